// File: rtl/sobel_csr_pkg.sv
// Shared constants for the Sobel engine Avalon-MM CSR block:
// register word addresses, CONTROL/STATUS bit positions, engine states.
package sobel_csr_pkg;

  // Register word addresses
  localparam int unsigned ADDR_CONTROL = 0;
  localparam int unsigned ADDR_STATUS  = 1;
  localparam int unsigned ADDR_CFG0    = 2;

  // CONTROL bit indices
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;

  // STATUS bit indices
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;

  // Engine sequencing states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } eng_state_t;

endpackage

// File: rtl/sobel_avs_csr.sv
// Avalon-MM slave CSR block for the Sobel engine: CONTROL/STATUS registers,
// NUM_CFG configuration registers, engine IDLE/RUN sequencing and sticky
// DONE/ERR flags. Read responses come back one cycle after the read strobe.
// Optional feature: define SOBEL_CSR_IRQ_EN to add the IRQ_EN bit and irq port.
module sobel_avs_csr
  import sobel_csr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NUM_CFG = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_W-1:0]         writedata,
  input  logic [DATA_W/8-1:0]       byteenable,
  output logic [DATA_W-1:0]         readdata,
  output logic                      readdatavalid,
  output logic                      start_o,
  output logic                      busy_o,
  output logic [NUM_CFG*DATA_W-1:0] cfg_o,
  input  logic                      done_i,
  input  logic                      err_i
`ifdef SOBEL_CSR_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int NBYTES = DATA_W / 8;

  eng_state_t           state_q, state_d;
  logic                 start_d;
  logic                 done_q, err_q, irq_en_q;
  logic [DATA_W-1:0]    cfg_q [NUM_CFG];
  logic [DATA_W-1:0]    rd_mux;
  logic [NUM_CFG-1:0]   cfg_hit;
  logic                 ctrl_wr, stat_wr, cfg_wr, start_req, running;
  logic                 done_set, done_clr, err_set, err_clr;

  // Address decode and write qualification
  always_comb begin
    cfg_hit = '0;
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      cfg_hit[k] = (address == ADDR_W'(ADDR_CFG0 + k));
    end
    ctrl_wr   = write && (address == ADDR_W'(ADDR_CONTROL)) && byteenable[0];
    stat_wr   = write && (address == ADDR_W'(ADDR_STATUS))  && byteenable[0];
    cfg_wr    = write && (|cfg_hit);
    start_req = ctrl_wr && writedata[CTRL_START];
  end

  assign running = (state_q == RUN);
  assign busy_o  = running;

  // Engine next-state and start pulse request
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state register and registered start pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      start_o <= 1'b0;
    end else begin
      state_q <= state_d;
      start_o <= start_d;
    end
  end

  // Sticky flag set/clear terms; a START or CFG write while running is an error
  always_comb begin
    done_set = running && done_i;
    done_clr = stat_wr && writedata[STAT_DONE];
    err_set  = err_i || (running && (start_req || cfg_wr));
    err_clr  = stat_wr && writedata[STAT_ERR];
  end

  // Sticky DONE/ERR registers, set has priority over W1C
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_set | (done_q & ~done_clr);
      err_q  <= err_set  | (err_q  & ~err_clr);
    end
  end

  // Configuration registers: byte-lane writes, frozen while running
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else if (cfg_wr && !running) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        if (cfg_hit[k]) begin
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (byteenable[b]) cfg_q[k][b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Flatten configuration registers onto cfg_o
  always_comb begin
    cfg_o = '0;
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      cfg_o[k*DATA_W +: DATA_W] = cfg_q[k];
    end
  end

`ifdef SOBEL_CSR_IRQ_EN
  // IRQ enable bit and registered interrupt output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      irq <= irq_en_q & (done_q | err_q);
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif

  // Read multiplexer over pre-update register contents
  always_comb begin
    rd_mux = '0;
    if (address == ADDR_W'(ADDR_CONTROL)) begin
      rd_mux[CTRL_IRQ_EN] = irq_en_q;
    end else if (address == ADDR_W'(ADDR_STATUS)) begin
      rd_mux[STAT_BUSY] = running;
      rd_mux[STAT_DONE] = done_q;
      rd_mux[STAT_ERR]  = err_q;
    end else begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        if (cfg_hit[k]) rd_mux = cfg_q[k];
      end
    end
  end

  // Read response register; a colliding write suppresses the response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else if (read && !write) begin
      readdata      <= rd_mux;
      readdatavalid <= 1'b1;
    end else begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end
  end

endmodule
